// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receiver.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled 8N1 UART receiver with sticky ready, framing-error and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rxclk_en,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam logic [3:0] SAMPLE_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST    = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_50m (clk_50m),
    .rst     (rst),
    .d       (rx),
    .q       (rx_s)
  );

  rx_state_t             state_q, state_d;
  logic [3:0]            sample_q, sample_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  rdy_q, rdy_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  good_done;

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    frame_err_d = frame_err_q;
    good_done   = 1'b0;

    if (rxclk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d  = ST_START;
            sample_d = 4'd0;
          end
        end
        ST_START: begin
          if (sample_q == SAMPLE_MID) begin
            sample_d = 4'd0;
            bitcnt_d = 3'd0;
            state_d  = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            sample_d = sample_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (sample_q == SAMPLE_LAST) begin
            shift_d[bitcnt_q] = rx_s;
            sample_d          = 4'd0;
            if (bitcnt_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end else begin
            sample_d = sample_q + 4'd1;
          end
        end
        ST_STOP: begin
          if (sample_q == SAMPLE_LAST) begin
            sample_d = 4'd0;
            state_d  = ST_IDLE;
            if (rx_s) begin
              data_d      = shift_q;
              frame_err_d = 1'b0;
              good_done   = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            sample_d = sample_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A completing frame beats a simultaneous acknowledge; only an unacknowledged overwrite is an overrun.
  always_comb begin
    rdy_d     = rdy_q;
    overrun_d = overrun_q;
    if (good_done) begin
      rdy_d = 1'b1;
      if (rdy_clr) begin
        overrun_d = 1'b0;
      end else if (rdy_q) begin
        overrun_d = 1'b1;
      end
    end else if (rdy_clr) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sample_q    <= 4'd0;
      bitcnt_q    <= 3'd0;
      shift_q     <= '0;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames on a 1-in-55 rxclk_en strobe, tick-aligned rx edges.
module tb_uart_rx;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic [5:0] div_q = 6'd0;
  logic       rxclk_en;

  int vectors     = 0;
  int miscompares = 0;

  logic       pre_rdy;
  logic [7:0] pre_data;

  uart_rx dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .rx        (rx),
    .rxclk_en  (rxclk_en),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk_50m = ~clk_50m;

  always @(posedge clk_50m) div_q <= (div_q == 6'd54) ? 6'd0 : div_q + 6'd1;
  assign rxclk_en = (div_q == 6'd54);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after the next rxclk_en tick edge.
  task automatic tick();
    do @(negedge clk_50m); while (!rxclk_en);
    @(negedge clk_50m);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m) rdy_clr = 1'b1;
    @(negedge clk_50m) rdy_clr = 1'b0;
  endtask

  // Stop-bit mid-sample lands on tick 153 after the start edge; optional ack on that exact cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic clr_at_done);
    tick();
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop;
    wait_ticks(8);
    do @(negedge clk_50m); while (!rxclk_en);
    pre_rdy  = rdy;
    pre_data = data;
    rdy_clr  = clr_at_done;
    @(posedge clk_50m);
    @(negedge clk_50m);
    rdy_clr = 1'b0;
    rx      = 1'b1;
    $display("frame %h stop=%0d clr=%0d -> data=%h rdy=%0d frame_err=%0d overrun=%0d",
             d, stop, clr_at_done, data, rdy, frame_err, overrun);
    wait_ticks(10);
  endtask

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    rdy_clr = 1'b0;
    repeat (3) @(negedge clk_50m);
    check("reset_data", data, 8'h00);
    check("reset_rdy", {7'd0, rdy}, 8'h00);
    check("reset_frame_err", {7'd0, frame_err}, 8'h00);
    check("reset_overrun", {7'd0, overrun}, 8'h00);
    rst = 1'b0;
    wait_ticks(3);

    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_pre_rdy", {7'd0, pre_rdy}, 8'h00);
    check("a5_pre_data", pre_data, 8'h00);
    check("a5_data", data, 8'hA5);
    check("a5_rdy", {7'd0, rdy}, 8'h01);
    check("a5_frame_err", {7'd0, frame_err}, 8'h00);
    check("a5_overrun", {7'd0, overrun}, 8'h00);
    pulse_clr();
    check("a5_clr_rdy", {7'd0, rdy}, 8'h00);

    tick();
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    $display("glitch 4 ticks -> data=%h rdy=%0d frame_err=%0d", data, rdy, frame_err);
    check("glitch_rdy", {7'd0, rdy}, 8'h00);
    check("glitch_data", data, 8'hA5);
    check("glitch_frame_err", {7'd0, frame_err}, 8'h00);

    send_frame(8'h3C, 1'b0, 1'b0);
    check("3c_frame_err", {7'd0, frame_err}, 8'h01);
    check("3c_rdy", {7'd0, rdy}, 8'h00);
    check("3c_data", data, 8'hA5);
    pulse_clr();
    check("3c_err_after_clr", {7'd0, frame_err}, 8'h01);

    send_frame(8'h5A, 1'b1, 1'b0);
    check("5a_frame_err", {7'd0, frame_err}, 8'h00);
    check("5a_data", data, 8'h5A);
    check("5a_rdy", {7'd0, rdy}, 8'h01);
    check("5a_overrun", {7'd0, overrun}, 8'h00);

    send_frame(8'h77, 1'b1, 1'b1);
    check("77_pre_rdy", {7'd0, pre_rdy}, 8'h01);
    check("77_rdy", {7'd0, rdy}, 8'h01);
    check("77_overrun", {7'd0, overrun}, 8'h00);
    check("77_data", data, 8'h77);
    pulse_clr();
    check("77_clr_rdy", {7'd0, rdy}, 8'h00);

    send_frame(8'h11, 1'b1, 1'b0);
    check("11_data", data, 8'h11);
    check("11_overrun", {7'd0, overrun}, 8'h00);
    send_frame(8'h22, 1'b1, 1'b0);
    check("22_data", data, 8'h22);
    check("22_rdy", {7'd0, rdy}, 8'h01);
    check("22_overrun", {7'd0, overrun}, 8'h01);
    pulse_clr();
    $display("rdy_clr pulse -> rdy=%0d overrun=%0d", rdy, overrun);
    check("22_clr_rdy", {7'd0, rdy}, 8'h00);
    check("22_clr_overrun", {7'd0, overrun}, 8'h00);

    // One full frame time of solid low, released right after its stop sample.
    tick();
    rx = 1'b0;
    wait_ticks(153);
    rx = 1'b1;
    wait_ticks(10);
    $display("rx held low -> data=%h rdy=%0d frame_err=%0d", data, rdy, frame_err);
    check("low_frame_err", {7'd0, frame_err}, 8'h01);
    check("low_rdy", {7'd0, rdy}, 8'h00);
    check("low_data", data, 8'h22);

    tick();
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(8);
    rst = 1'b1;
    #1;
    $display("reset mid-frame -> data=%h rdy=%0d frame_err=%0d overrun=%0d", data, rdy, frame_err, overrun);
    check("rst_mid_data", data, 8'h00);
    check("rst_mid_rdy", {7'd0, rdy}, 8'h00);
    check("rst_mid_frame_err", {7'd0, frame_err}, 8'h00);
    check("rst_mid_overrun", {7'd0, overrun}, 8'h00);
    @(negedge clk_50m);
    rst = 1'b0;
    wait_ticks(20);
    check("rst_release_rdy", {7'd0, rdy}, 8'h00);
    check("rst_release_data", data, 8'h00);

    send_frame(8'hC3, 1'b1, 1'b0);
    check("c3_data", data, 8'hC3);
    check("c3_rdy", {7'd0, rdy}, 8'h01);
    check("c3_frame_err", {7'd0, frame_err}, 8'h00);
    check("c3_overrun", {7'd0, overrun}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, 16, rxclk_en ticks per bit period; fixed at 16.
REQ-002 Parameter DATA_BITS, 8, data bits per frame; fixed at 8, LSB first.
REQ-003 Port clk_50m  input  1  single system clock; all flops use its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port rx  input  1  raw asynchronous serial line; idles high.
REQ-006 Port rxclk_en  input  1  one-cycle strobe at 16x baud from the baud generator.
REQ-007 Port rdy_clr  input  1  consumer acknowledge; clears rdy and overrun.
REQ-008 Port data  output  8  last correctly framed byte.
REQ-009 Port rdy  output  1  byte available in data; sticky until rdy_clr.
REQ-010 Port frame_err  output  1  last frame had stop bit low.
REQ-011 Port overrun  output  1  byte completed while rdy was still set and not being cleared.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (rx_s); 2-cycle latency, no other filtering.
REQ-013 State, sample counter (4 bits) and bit counter (3 bits) SHALL change only on cycles with rxclk_en=1; rdy_clr and rst act on any cycle.
REQ-014 States: IDLE, START, DATA, STOP.
REQ-015 IDLE: tick with rx_s=0 -> START, sample=0.
REQ-016 START: sample increments per tick; at tick with sample=7 (mid start bit): rx_s=0 -> DATA, sample=0, bitcnt=0; rx_s=1 -> IDLE (glitch reject, no output change).
REQ-017 DATA: at tick with sample=15, rx_s SHALL be written to shift-register bit bitcnt, sample=0; bitcnt=7 -> STOP, else bitcnt+1.
REQ-018 STOP: at tick with sample=15: rx_s=1 -> data<=shift reg, rdy<=1, frame_err<=0; rx_s=0 -> frame_err<=1, data and rdy unchanged; either case -> IDLE.
REQ-019 rdy/data/frame_err SHALL update on the clock edge of the STOP mid-bit tick (registered, 1-cycle latency from that tick).
REQ-020 Good-frame completion with rdy=1 and rdy_clr=0 SHALL set overrun=1; data overwritten with new byte.
REQ-021 rdy_clr=1 with no completion on that cycle SHALL clear rdy and overrun next edge.
REQ-022 rdy_clr=1 on the same cycle as good completion: rdy=1, overrun=0 (set wins, no overrun).
REQ-023 frame_err SHALL stay set until the next good frame; rdy_clr does not affect it.
REQ-024 Counters SHALL never exceed their stated range; sample wraps 15->0 only via REQ-017/018 resets.
REQ-025 rx held low continuously SHALL produce frame_err each frame, never rdy.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, counters 0, shift reg 0, data=0, rdy=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-027 rst asserted mid-frame SHALL abandon the frame; no output changes on release; reception resumes from IDLE at next low rx_s tick.

Structure
REQ-028 State encoding (2-bit) and OVERSAMPLE/DATA_BITS constants SHALL live in shared package uart_pkg.
REQ-029 The 2-flop synchronizer SHALL be sub-module sync_2ff (reset value parameterized, 1 here).
REQ-030 Single always block per register group; no latches; no clocks other than clk_50m.

Verification
Bench drives rxclk_en as a 1-in-55 strobe (bit period 880 clocks), frames 8N1.
REQ-031 Frame 0xA5, stop=1 -> data=0xA5, rdy=1, frame_err=0, overrun=0 within 1 cycle after STOP mid tick.
REQ-032 rx low for 4 ticks then high -> START aborts to IDLE, rdy stays 0, data unchanged.
REQ-033 Frame 0x3C with stop=0 -> frame_err=1, rdy=0, data keeps prior value; next good 0x5A -> frame_err=0, data=0x5A.
REQ-034 Frames 0x11 then 0x22 without rdy_clr -> data=0x22, rdy=1, overrun=1; rdy_clr pulse -> rdy=0, overrun=0.
REQ-035 rdy_clr asserted on the exact completion cycle of 0x77 while rdy=1 -> rdy=1, overrun=0, data=0x77.
REQ-036 rst pulsed during data bit 4 of a frame -> all outputs 0 immediately; subsequent frame 0xC3 received correctly.
